// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Direction counter encodings and the saturating counter step.
package btb_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT  = 2'd0;
  localparam cnt_t CNT_WNT  = 2'd1;
  localparam cnt_t CNT_WT   = 2'd2;
  localparam cnt_t CNT_ST   = 2'd3;
  localparam cnt_t CNT_INIT = CNT_WT;

  function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Allocation-way picker for one set: lowest invalid way first, otherwise the
// round-robin pointer, which then advances.
module btb_victim_sel #(
  parameter int WAYS  = 2,
  parameter int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] alloc_way,
  output logic [PTR_W-1:0] ptr_next
);

  logic             full;
  logic [PTR_W-1:0] ptr_inc;

  // WAYS is a power of two, so the pointer wraps naturally on overflow.
  assign ptr_inc = (WAYS == 1) ? '0 : ptr + 1'b1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    full      = 1'b1;
    alloc_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        full      = 1'b0;
        alloc_way = PTR_W'(w);
      end
    end
    if (full) alloc_way = ptr;
    ptr_next = full ? ptr_inc : ptr;
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters: combinational fetch
// lookup, one resolved-branch update per cycle, flush and stall-hold.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2,
  parameter int TAG_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_read,
  output logic              hit,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]   valid_q  [SETS];
  logic [PTR_W-1:0]  ptr_q    [SETS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [ADDR_W-1:0] target_q [SETS][WAYS];
  cnt_t              cnt_q    [SETS][WAYS];

  logic [INDEX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0]   rd_tag, upd_tag;

  assign rd_idx  = pc_read[INDEX_W+1:2];
  assign rd_tag  = pc_read[INDEX_W+TAG_W+1:INDEX_W+2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
  assign upd_tag = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  // Byte-offset and above-tag PC bits take no part in indexing or matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_read, upd_pc};

  // Fetch-side lookup
  logic              rd_hit;
  cnt_t              rd_cnt;
  logic [ADDR_W-1:0] rd_target;
  logic              out_en;

  always_comb begin
    rd_hit    = 1'b0;
    rd_cnt    = CNT_SNT;
    rd_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
        rd_hit    = 1'b1;
        rd_cnt    = cnt_q[rd_idx][w];
        rd_target = target_q[rd_idx][w];
      end
    end
  end

  assign out_en = !rst && rdy;
  assign hit    = out_en && rd_hit;
  assign taken  = hit && rd_cnt[1];
  assign target = hit ? rd_target : '0;

  // Update-side lookup
  logic             upd_hit;
  logic [PTR_W-1:0] upd_way;
  logic [PTR_W-1:0] alloc_way;
  logic [PTR_W-1:0] ptr_next;
  logic             upd_en;

  always_comb begin
    upd_hit = 1'b0;
    upd_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        upd_hit = 1'b1;
        upd_way = PTR_W'(w);
      end
    end
  end

  btb_victim_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim_sel (
    .valid     (valid_q[upd_idx]),
    .ptr       (ptr_q[upd_idx]),
    .alloc_way (alloc_way),
    .ptr_next  (ptr_next)
  );

  // Flush and reset win over a same-cycle update.
  assign upd_en = upd_valid && rdy && !rst && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (upd_en && !upd_hit && upd_taken) begin
      valid_q[upd_idx][alloc_way] <= 1'b1;
      ptr_q[upd_idx]              <= ptr_next;
    end
  end

  // NOTE: tag, target and counter arrays carry no reset; an entry is only
  // ever read once its valid bit is set, which also initialises them.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (upd_hit) begin
        cnt_q[upd_idx][upd_way] <= cnt_next(cnt_q[upd_idx][upd_way], upd_taken);
        if (upd_taken) target_q[upd_idx][upd_way] <= upd_target;
      end else if (upd_taken) begin
        tag_q[upd_idx][alloc_way]    <= upd_tag;
        target_q[upd_idx][alloc_way] <= upd_target;
        cnt_q[upd_idx][alloc_way]    <= CNT_INIT;
      end
    end
  end

endmodule
